// File: rtl/scoreboard_driver_pkg.sv
// Shared constants for the scoreboard display driver.
//   NUM_DIGITS        : number of physical digits scanned (ports sized for 8)
//   SEG_0 .. SEG_9    : active-low segment patterns, bit0=a .. bit6=g
//   SEG_BLANK         : all segments off
//   seg_encode()      : BCD nibble -> segment pattern, non-decimal -> blank
package scoreboard_driver_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/scoreboard_driver_bin16_to_bcd5.sv
// Combinational 16-bit binary to 5-digit BCD converter (double-dabble).
//   bin : unsigned binary input, 0..65535
//   bcd : bcd[0] = ones ... bcd[4] = ten-thousands
module bin16_to_bcd5 (
    input  logic [15:0]      bin,
    output logic [4:0][3:0]  bcd
);

    // Working register: BCD digits in [35:16], binary shifted out of [15:0].
    logic [35:0] sr;

    always_comb begin
        sr = {20'd0, bin};
        for (int i = 0; i < 16; i++) begin
            // Correct any digit >= 5 before the shift so it carries as decimal.
            for (int j = 0; j < 5; j++) begin
                if (sr[16 + 4*j +: 4] >= 4'd5) begin
                    sr[16 + 4*j +: 4] = sr[16 + 4*j +: 4] + 4'd3;
                end
            end
            sr = sr << 1;
        end
    end

    assign bcd = sr[35:16];

endmodule

// File: rtl/scoreboard_driver.sv
// Scans an 8-digit multiplexed 7-segment display showing a 16-bit score
// in decimal, right-aligned, with optional leading-zero blanking.
//   R_clk_1000HZ : 1 kHz scan clock, rising edge
//   I_rst_n      : synchronous active-low reset
//   score        : unsigned binary score, may change on any cycle
//   O_shift      : digit enables, active-low, bit 0 = rightmost digit
//   O_data       : segment drive, active-low, bit0=a .. bit6=g
module scoreboard_driver
    import scoreboard_driver_pkg::*;
#(
    parameter int NUM_DIGITS    = scoreboard_driver_pkg::NUM_DIGITS,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        R_clk_1000HZ,
    input  logic        I_rst_n,
    input  logic [15:0] score,
    output logic [7:0]  O_shift,
    output logic [6:0]  O_data
);

    logic [2:0]      scan_idx;
    logic [4:0][3:0] bcd;
    logic [3:0]      nib;
    logic            show;
    logic [6:0]      seg_next;

    bin16_to_bcd5 u_bcd (
        .bin (score),
        .bcd (bcd)
    );

    // Select the digit for the position being scanned. A digit above the
    // ones place is blanked when it and every higher digit are zero; digit 0
    // is always shown so a zero score still displays "0".
    always_comb begin
        nib  = 4'd0;
        show = 1'b0;
        case (scan_idx)
            3'd0: begin nib = bcd[0]; show = 1'b1; end
            3'd1: begin nib = bcd[1]; show = !(BLANK_LEADING && (bcd[4:1] == '0)); end
            3'd2: begin nib = bcd[2]; show = !(BLANK_LEADING && (bcd[4:2] == '0)); end
            3'd3: begin nib = bcd[3]; show = !(BLANK_LEADING && (bcd[4:3] == '0)); end
            3'd4: begin nib = bcd[4]; show = !(BLANK_LEADING && (bcd[4]   == '0)); end
            default: begin nib = 4'd0; show = 1'b0; end
        endcase
        seg_next = show ? seg_encode(nib) : SEG_BLANK;
    end

    always_ff @(posedge R_clk_1000HZ) begin
        if (!I_rst_n) begin
            scan_idx <= 3'd0;
            O_shift  <= 8'hFF;
            O_data   <= SEG_BLANK;
        end else begin
            O_shift  <= ~(8'b1 << scan_idx);
            O_data   <= seg_next;
            scan_idx <= (scan_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_scoreboard_driver.sv
// Self-checking bench for scoreboard_driver: directed score patterns,
// decade boundaries, then random scores with a mid-frame reset, compared
// against a decimal-arithmetic model of the display.
module tb_scoreboard_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] score;
    logic [7:0]  o_shift;
    logic [6:0]  o_data;

    int checks   = 0;
    int failures = 0;

    // Model state: which display position the next enabled edge drives.
    int m_pos = 0;

    logic [14:0] exp_q[$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    scoreboard_driver dut (
        .R_clk_1000HZ (clk),
        .I_rst_n      (rst_n),
        .score        (score),
        .O_shift      (o_shift),
        .O_data       (o_data)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected segment pattern for display position pos showing value s.
    function automatic logic [6:0] exp_seg(input int s, input int pos);
        int p10;
        p10 = 1;
        for (int k = 0; k < pos; k++) p10 = p10 * 10;
        if (pos >= 5) return 7'h7F;
        if (pos > 0 && s < p10) return 7'h7F;
        return seg_tab[(s / p10) % 10];
    endfunction

    // Driver: apply inputs away from the edge, queue the expectation,
    // then compare just after the rising edge.
    task automatic step(input logic [15:0] s, input logic r, input string tag);
        logic [14:0] e;
        @(negedge clk);
        score = s;
        rst_n = r;
        if (!r) begin
            exp_q.push_back({8'hFF, 7'h7F});
            m_pos = 0;
        end else begin
            e[14:7] = ~(8'(1) << m_pos);
            e[6:0]  = exp_seg(int'(s), m_pos);
            exp_q.push_back(e);
            m_pos = (m_pos + 1) % 8;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_shift"}, 16'(o_shift), 16'(e[14:7]));
        check({tag, "_data"},  16'(o_data),  16'(e[6:0]));
    endtask

    task automatic frame(input logic [15:0] s, input string tag);
        for (int c = 0; c < 8; c++) step(s, 1'b1, tag);
    endtask

    logic [15:0] dir_vals [15] = '{16'd0, 16'd5, 16'd60, 16'd198, 16'd2378,
                                   16'd65535, 16'd9, 16'd10, 16'd99, 16'd100,
                                   16'd999, 16'd1000, 16'd9999, 16'd10000, 16'd40305};

    initial begin
        logic [15:0] rs;
        rst_n = 1'b0;
        score = 16'd0;

        for (int c = 0; c < 3; c++) step(16'd0, 1'b0, "reset");
        step(16'd0, 1'b1, "first");

        // Realign to digit 0, then directed frames (wrap covered by 2 frames).
        for (int c = 0; c < 7; c++) step(16'd0, 1'b1, "zero");
        foreach (dir_vals[i]) begin
            frame(dir_vals[i], "dir");
            frame(dir_vals[i], "dir2");
        end

        // Random scores held for 20 cycles, with one reset mid-frame.
        for (int blk = 0; blk < 12; blk++) begin
            rs = 16'($urandom_range(0, 65535));
            for (int c = 0; c < 20; c++) begin
                if (blk == 5 && (c == 3 || c == 4)) step(rs, 1'b0, "midrst");
                else step(rs, 1'b1, "rnd");
            end
        end

        // Score changing every cycle: 1-cycle latency per digit.
        for (int c = 0; c < 64; c++) begin
            rs = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            step(rs, 1'b1, "fast");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
